// File: rtl/enc_pwm_mixer.sv
// N-channel quadrature encoder to PWM mixer with debug level readback.
// Optional build macro SATURATE_EN: levels clamp at 0 and 2^VAL_W-1 instead of wrapping.
module enc_pwm_mixer #(
    parameter int NUM_CH       = 3,
    parameter int VAL_W        = 8,
    parameter int DEBOUNCE_LEN = 3,
    parameter int STEP         = 1,
    parameter int SEL_W        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enc_a,
    input  logic [NUM_CH-1:0] enc_b,
    output logic [NUM_CH-1:0] pwm_out,
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [VAL_W-1:0]  dbg_value
);

    localparam logic [VAL_W-1:0] STEP_V = VAL_W'(STEP);
    localparam logic [VAL_W-1:0] MAX_V  = '1;

    logic [NUM_CH-1:0] step;
    logic [NUM_CH-1:0] step_dn;
    logic [VAL_W-1:0]  level [NUM_CH];
    logic [VAL_W-1:0]  duty  [NUM_CH];
    logic [VAL_W-1:0]  pwm_cnt;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            // bit 0 carries phase A, bit 1 carries phase B
            logic [1:0]              s1;
            logic [1:0]              s2;
            logic [1:0]              deb;
            logic [1:0]              deb_next;
            logic [DEBOUNCE_LEN-1:0] sh_a;
            logic [DEBOUNCE_LEN-1:0] sh_b;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1   <= '0;
                    s2   <= '0;
                    sh_a <= '0;
                    sh_b <= '0;
                    deb  <= '0;
                end else begin
                    s1   <= {enc_b[i], enc_a[i]};
                    s2   <= s1;
                    sh_a <= (sh_a << 1) | DEBOUNCE_LEN'(s2[0]);
                    sh_b <= (sh_b << 1) | DEBOUNCE_LEN'(s2[1]);
                    deb  <= deb_next;
                end
            end

            // The newest synchronised sample must also agree, so a pulse needs
            // DEBOUNCE_LEN+1 stable cycles before it is accepted.
            always_comb begin
                deb_next = deb;
                if ((&sh_a) && s2[0]) begin
                    deb_next[0] = 1'b1;
                end else if (!(|sh_a) && !s2[0]) begin
                    deb_next[0] = 1'b0;
                end
                if ((&sh_b) && s2[1]) begin
                    deb_next[1] = 1'b1;
                end else if (!(|sh_b) && !s2[1]) begin
                    deb_next[1] = 1'b0;
                end
            end

            assign step[i]    = deb_next[0] & ~deb[0];
            assign step_dn[i] = deb[1];
        end
    endgenerate

    function automatic logic [VAL_W-1:0] next_level(input logic [VAL_W-1:0] cur,
                                                    input logic             dn);
        logic [VAL_W-1:0] res;
`ifdef SATURATE_EN
        if (dn) begin
            res = (cur < STEP_V) ? '0 : cur - STEP_V;
        end else begin
            res = (cur > MAX_V - STEP_V) ? MAX_V : cur + STEP_V;
        end
`else
        res = dn ? cur - STEP_V : cur + STEP_V;
`endif
        return res;
    endfunction

    // Shadow duty is reloaded only at the last count so a running period is never altered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            pwm_out <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                level[c] <= '0;
                duty[c]  <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                pwm_out[c] <= (pwm_cnt < duty[c]);
                if (pwm_cnt == MAX_V) begin
                    duty[c] <= level[c];
                end
                if (step[c]) begin
                    level[c] <= next_level(level[c], step_dn[c]);
                end
            end
        end
    end

    always_comb begin
        dbg_value = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (dbg_sel == SEL_W'(c)) begin
                dbg_value = level[c];
            end
        end
    end

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// Directed bench for enc_pwm_mixer: spec-level model checked every cycle plus literal checkpoints.
module tb_enc_pwm_mixer;

    localparam int NUM_CH = 3;
    localparam int VAL_W  = 8;
    localparam int DL     = 3;
    localparam int STEP   = 1;
    localparam int SEL_W  = 2;
    localparam int MAXV   = (1 << VAL_W) - 1;
    localparam int PER    = 1 << VAL_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] enc_a = '0;
    logic [NUM_CH-1:0] enc_b = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic [SEL_W-1:0]  dbg_sel = '0;
    logic [VAL_W-1:0]  dbg_value;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enc_pwm_mixer #(
        .NUM_CH(NUM_CH), .VAL_W(VAL_W), .DEBOUNCE_LEN(DL), .STEP(STEP), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .reset(rst), .enc_a(enc_a), .enc_b(enc_b),
        .pwm_out(pwm_out), .dbg_sel(dbg_sel), .dbg_value(dbg_value)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // History of raw pin samples per edge; a pin is accepted once the DL+1 samples taken
    // 2..DL+2 edges ago all agree (two-edge synchroniser delay).
    int              m_level [NUM_CH];
    int              m_duty  [NUM_CH];
    bit              m_deb_a [NUM_CH];
    bit              m_deb_b [NUM_CH];
    logic [15:0]     h_a     [NUM_CH];
    logic [15:0]     h_b     [NUM_CH];
    logic [NUM_CH-1:0] m_pwm;
    int              m_cnt;

    function automatic bit settle(input logic [15:0] h, input bit cur);
        bit all1 = 1'b1;
        bit all0 = 1'b1;
        for (int j = 2; j <= DL + 2; j++) begin
            all1 &= h[j];
            all0 &= ~h[j];
        end
        if (all1) return 1'b1;
        if (all0) return 1'b0;
        return cur;
    endfunction

    function automatic int bump(input int cur, input bit dn);
`ifdef SATURATE_EN
        if (dn) return (cur - STEP < 0) ? 0 : cur - STEP;
        return (cur + STEP > MAXV) ? MAXV : cur + STEP;
`else
        if (dn) return (cur - STEP + PER) % PER;
        return (cur + STEP) % PER;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            m_pwm = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_level[c] = 0; m_duty[c] = 0;
                m_deb_a[c] = 0; m_deb_b[c] = 0;
                h_a[c] = '0; h_b[c] = '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) m_pwm[c] = (m_cnt < m_duty[c]);
            if (m_cnt == MAXV) for (int c = 0; c < NUM_CH; c++) m_duty[c] = m_level[c];
            m_cnt = (m_cnt + 1) % PER;
            for (int c = 0; c < NUM_CH; c++) begin
                bit na, nb;
                h_a[c] = {h_a[c][14:0], enc_a[c]};
                h_b[c] = {h_b[c][14:0], enc_b[c]};
                na = settle(h_a[c], m_deb_a[c]);
                nb = settle(h_b[c], m_deb_b[c]);
                if (na && !m_deb_a[c]) m_level[c] = bump(m_level[c], m_deb_b[c]);
                m_deb_a[c] = na;
                m_deb_b[c] = nb;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        int exp_dbg;
        #2;
        exp_dbg = 0;
        if (int'(dbg_sel) < NUM_CH) exp_dbg = m_level[int'(dbg_sel)];
        check("pwm_cycle", int'(pwm_out), int'(m_pwm));
        check("dbg_cycle", int'(dbg_value), exp_dbg);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic detent(input int ch, input bit dn, input int h);
        enc_b[ch] = dn;
        tick(h);
        enc_a[ch] = 1'b1;
        tick(h);
        enc_a[ch] = 1'b0;
        tick(h);
    endtask

    task automatic lit(input string name, input int sel, input int exp);
        dbg_sel = SEL_W'(sel);
        #1;
        check(name, int'(dbg_value), exp);
    endtask

    // Wait until the output sample reflects pwm_cnt == 0.
    task automatic align(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < PER + 8 && !ok; k++) begin
            @(posedge clk);
            #2;
            if (m_cnt == 1) ok = 1'b1;
        end
        if (!ok) check("align_timeout", 0, 1);
    endtask

    task automatic count_period(output int highs);
        highs = int'(pwm_out[0]);
        repeat (PER - 1) begin
            @(posedge clk);
            #2;
            highs += int'(pwm_out[0]);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  highs;
        bit  ok;

        // reset held while inputs toggle
        tick(1);
        repeat (12) begin
            enc_a = NUM_CH'($urandom_range(0, 7));
            enc_b = NUM_CH'($urandom_range(0, 7));
            tick(1);
        end
        check("rst_pwm", int'(pwm_out), 0);
        for (int s = 0; s < 4; s++) lit("rst_dbg", s, 0);
        enc_a = '0;
        enc_b = '0;
        tick(1);
        rst = 1'b0;
        tick(10);

        // five clean up detents on channel 0
        repeat (5) detent(0, 1'b0, 10);
        tick(10);
        lit("ch0_five", 0, 5);
        lit("ch1_idle", 1, 0);
        lit("ch2_idle", 2, 0);

        // channel 1 bound behaviour
        detent(1, 1'b1, 5);
        tick(5);
`ifdef SATURATE_EN
        lit("ch1_dn_from0", 1, 0);
        repeat (255) detent(1, 1'b0, 5);
        tick(5);
        lit("ch1_to_max", 1, 255);
        detent(1, 1'b0, 5);
        tick(5);
        lit("ch1_up_from_max", 1, 255);
`else
        lit("ch1_dn_from0", 1, 255);
        detent(1, 1'b0, 5);
        tick(5);
        lit("ch1_up_from_max", 1, 0);
`endif

        // channel 2 glitch rejection and exact latency
        dbg_sel = 2'd2;
        enc_a[2] = 1'b1;
        tick(2);
        enc_a[2] = 1'b0;
        tick(12);
        lit("ch2_glitch", 2, 0);
        enc_a[2] = 1'b1;
        repeat (DL + 2) @(posedge clk);
        #1;
        check("ch2_lat_before", int'(dbg_value), 0);
        @(posedge clk);
        #1;
        check("ch2_lat_edge", int'(dbg_value), 1);
        tick(5);
        enc_a[2] = 1'b0;
        tick(10);
        lit("ch2_fall_nostep", 2, 1);

        // simultaneous step on every channel
        dbg_sel = 2'd0;
        enc_a = '1;
        repeat (DL + 2) @(posedge clk);
        #1;
        check("all_lat_before", int'(dbg_value), 5);
        @(posedge clk);
        #1;
        check("all_ch0", int'(dbg_value), 6);
        tick(10);
        enc_a = '0;
        tick(10);
`ifdef SATURATE_EN
        lit("all_ch1", 1, 255);
`else
        lit("all_ch1", 1, 1);
`endif
        lit("all_ch2", 2, 2);
        lit("sel_out_of_range", 3, 0);

        // PWM duty on channel 0, shadow protects the running period
        repeat (58) detent(0, 1'b0, 4);
        tick(10);
        lit("ch0_64", 0, 64);
        align(ok);
        count_period(highs);
        align(ok);
        count_period(highs);
        check("pwm_duty_64", highs, 64);
        align(ok);
        fork
            count_period(highs);
            begin
                tick(1);
                repeat (64) detent(0, 1'b0, 4);
            end
        join
        check("pwm_mid_change", highs, 64);
        tick(10);
        lit("ch0_128", 0, 128);
        align(ok);
        count_period(highs);
        check("pwm_duty_128", highs, 128);

        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
